// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter.
//   - default raster geometry and framebuffer address width
//   - port-owner state encoding
//   - linear pixel address helper: y * x_pixels + x
package fb_pkg;

    localparam int X_PIXELS = 800;
    localparam int Y_PIXELS = 600;
    localparam int ADDR_W   = 19;
    localparam int FB_WORDS = X_PIXELS * Y_PIXELS;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        HBLANK = 2'd1,
        VBLANK = 2'd2
    } fb_state_e;

    // Row-major linear address. Width is fixed at 32 bits; callers
    // truncate to their own address width.
    function automatic logic [31:0] lin_addr(input logic [9:0]  x,
                                             input logic [9:0]  y,
                                             input int unsigned xpix);
        return ({22'd0, y} * xpix) + {22'd0, x};
    endfunction

endpackage

// File: rtl/fb_port_arbiter_rr.sv
// Round-robin arbiter with a registered pointer.
// Ports:
//   clock, reset : pixel clock, async active-low reset
//   iReq[N]      : request levels
//   iEnable      : when low no grant is issued and the pointer holds
//   oGnt[N]      : one-hot grant, combinational from iReq and the pointer
// The pointer holds the index of the last granted requester; the search
// starts at pointer+1 and wraps. Reset value N-1 makes requester 0 win first.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] iReq,
    input  logic         iEnable,
    output logic [N-1:0] oGnt
);

    localparam int           PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]  NW = (PW + 1)'(N);

    logic [PW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [PW-1:0] w_gnt_idx;
    logic          w_any;
    logic [PW:0]   w_sum;

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = r_ptr;
        w_any     = 1'b0;
        w_sum     = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_sum >= NW)
                w_sum = w_sum - NW;
            if (!w_any && iReq[w_sum[PW-1:0]]) begin
                w_any                = 1'b1;
                w_gnt[w_sum[PW-1:0]] = 1'b1;
                w_gnt_idx            = w_sum[PW-1:0];
            end
        end
        if (!iEnable) begin
            w_gnt = '0;
            w_any = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ptr <= PW'(N - 1);
        else if (w_any)
            r_ptr <= w_gnt_idx;
    end

    assign oGnt = w_gnt;

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port owner: shares one synchronous RAM port between
// VGA scan-out reads and NUM_REQ round-robin writers.
// Ports:
//   clock, reset          : pixel clock, async active-low reset
//   iX, iY, iActive       : raster position and visible-pixel flag
//   iReq, iAddr, iData    : writer request level, address, data (writer i at slice i)
//   oGnt                  : one-hot accept pulse; the write is taken at the end of this cycle
//   oMemAddr/We/Wdata     : registered RAM port
//   iMemRdata             : RAM read data, one cycle after the address
//   oPixel, oPixelValid   : scan-out pixel, iActive delayed three cycles
//   oVblank, oFrameDone   : vertical blank state and its entry pulse
//   oAddrErr              : sticky, a granted write was outside the framebuffer
// Scan-out always wins while iActive is high. Writers are served only while
// the registered state is a permitted blanking window, so the first cycle
// after iActive falls (state still SCAN) and the first active cycle never grant.
module fb_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int X_PIXELS    = fb_pkg::X_PIXELS,
    parameter int Y_PIXELS    = fb_pkg::Y_PIXELS,
    parameter int ADDR_W      = fb_pkg::ADDR_W,
    parameter int DATA_W      = 8,
    parameter int VBLANK_ONLY = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [9:0]                iX,
    input  logic [9:0]                iY,
    input  logic                      iActive,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
    input  logic [NUM_REQ*DATA_W-1:0] iData,
    output logic [NUM_REQ-1:0]        oGnt,
    output logic [ADDR_W-1:0]         oMemAddr,
    output logic                      oMemWe,
    output logic [DATA_W-1:0]         oMemWdata,
    input  logic [DATA_W-1:0]         iMemRdata,
    output logic [DATA_W-1:0]         oPixel,
    output logic                      oPixelValid,
    output logic                      oVblank,
    output logic                      oFrameDone,
    output logic                      oAddrErr
);

    import fb_pkg::fb_state_e;
    import fb_pkg::SCAN;
    import fb_pkg::HBLANK;
    import fb_pkg::VBLANK;
    import fb_pkg::lin_addr;

    // bit 0: address on the port, bit 1: RAM data back, bit 2: pixel out
    localparam int                RD_STAGES = 2;
    localparam logic [9:0]        Y_LAST    = 10'(Y_PIXELS - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(X_PIXELS * Y_PIXELS);

    fb_state_e             r_state, w_state_nxt;
    logic                  r_prev_active;
    logic                  w_rise, w_fall;
    logic                  w_win_open, w_arb_en;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_wr_go, w_in_range;
    logic [ADDR_W-1:0]     w_rd_addr, w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;

    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_pixel;
    logic [RD_STAGES:0]    r_vld_pipe;
    logic                  r_frame_done;
    logic                  r_addr_err;

    // ------------------------------------------------------------------
    // Port-owner state
    // ------------------------------------------------------------------
    assign w_rise = iActive & ~r_prev_active;
    assign w_fall = ~iActive & r_prev_active;

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise)
            w_state_nxt = SCAN;
        else if (w_fall)
            w_state_nxt = (iY == Y_LAST) ? VBLANK : HBLANK;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= VBLANK;
            r_prev_active <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_active <= iActive;
            r_frame_done  <= (w_state_nxt == VBLANK) && (r_state != VBLANK);
        end
    end

    // ------------------------------------------------------------------
    // Writer arbitration
    // ------------------------------------------------------------------
    assign w_win_open = (r_state == VBLANK) ||
                        ((VBLANK_ONLY == 0) && (r_state == HBLANK));

    // reset is folded in so no accept pulse can be seen while held in reset
    assign w_arb_en = reset & ~iActive & w_win_open;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clock   (clock),
        .reset   (reset),
        .iReq    (iReq),
        .iEnable (w_arb_en),
        .oGnt    (w_gnt)
    );

    assign w_wr_go = |w_gnt;

    // one-hot grant, so an OR-mux is enough
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_wr_addr = w_wr_addr | iAddr[i*ADDR_W +: ADDR_W];
                w_wr_data = w_wr_data | iData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_in_range = ({1'b0, w_wr_addr} < FB_LIMIT);
    assign w_rd_addr  = ADDR_W'(lin_addr(iX, iY, X_PIXELS));

    // ------------------------------------------------------------------
    // RAM port and read-return pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_addr_err  <= 1'b0;
        end else if (iActive) begin
            r_mem_addr <= w_rd_addr;
            r_mem_we   <= 1'b0;
        end else if (w_wr_go) begin
            r_mem_addr  <= w_wr_addr;
            r_mem_wdata <= w_wr_data;
            r_mem_we    <= w_in_range;
            if (!w_in_range)
                r_addr_err <= 1'b1;
        end else begin
            r_mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_pixel    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_STAGES-1:0], iActive};
            if (r_vld_pipe[RD_STAGES-1])
                r_pixel <= iMemRdata;
        end
    end

    assign oGnt        = w_gnt;
    assign oMemAddr    = r_mem_addr;
    assign oMemWe      = r_mem_we;
    assign oMemWdata   = r_mem_wdata;
    assign oPixel      = r_pixel;
    assign oPixelValid = r_vld_pipe[RD_STAGES];
    assign oVblank     = (r_state == VBLANK);
    assign oFrameDone  = r_frame_done;
    assign oAddrErr    = r_addr_err;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int NR = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [9:0]        iX, iY;
    logic              iActive;
    logic [NR-1:0]     iReq, iReq_v;
    logic [NR*AW-1:0]  iAddr;
    logic [NR*DW-1:0]  iData;
    logic [NR-1:0]     oGnt, v_oGnt;
    logic [AW-1:0]     oMemAddr, v_oMemAddr;
    logic              oMemWe, v_oMemWe;
    logic [DW-1:0]     oMemWdata, v_oMemWdata;
    logic [DW-1:0]     iMemRdata;
    logic [DW-1:0]     oPixel, v_oPixel;
    logic              oPixelValid, v_oPixelValid;
    logic              oVblank, v_oVblank;
    logic              oFrameDone, v_oFrameDone;
    logic              oAddrErr, v_oAddrErr;

    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;

    int                tests = 0;
    int                fails = 0;

    logic [NR-1:0]     gnt_q[$];
    wr_t               wr_q[$];
    logic [DW-1:0]     pix_q[$];

    always #5 clock = ~clock;

    fb_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .VBLANK_ONLY(0)) dut (
        .clock(clock), .reset(reset), .iX(iX), .iY(iY), .iActive(iActive),
        .iReq(iReq), .iAddr(iAddr), .iData(iData), .oGnt(oGnt),
        .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemWdata(oMemWdata),
        .iMemRdata(iMemRdata), .oPixel(oPixel), .oPixelValid(oPixelValid),
        .oVblank(oVblank), .oFrameDone(oFrameDone), .oAddrErr(oAddrErr)
    );

    // vertical-blank-only variant, observed for grant gating only
    fb_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .VBLANK_ONLY(1)) dut_v (
        .clock(clock), .reset(reset), .iX(iX), .iY(iY), .iActive(iActive),
        .iReq(iReq_v), .iAddr(iAddr), .iData(iData), .oGnt(v_oGnt),
        .oMemAddr(v_oMemAddr), .oMemWe(v_oMemWe), .oMemWdata(v_oMemWdata),
        .iMemRdata(8'h00), .oPixel(v_oPixel), .oPixelValid(v_oPixelValid),
        .oVblank(v_oVblank), .oFrameDone(v_oFrameDone), .oAddrErr(v_oAddrErr)
    );

    // synchronous single-port RAM, read data one cycle after the address
    always @(posedge clock) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (oMemWe)
            mem[oMemAddr] <= oMemWdata;
        iMemRdata <= mem[oMemAddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (oGnt != '0) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(oGnt), 32'd0);
            else                   chk("gnt_order", 32'(oGnt), 32'(gnt_q.pop_front()));
        end
        if (oMemWe) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 32'(oMemWe), 32'd0);
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(oMemAddr), 32'(e.a));
                chk("wr_data", 32'(oMemWdata), 32'(e.d));
            end
        end
        if (oPixelValid) begin
            if (pix_q.size() == 0) chk("pix_unexpected", 32'(oPixelValid), 32'd0);
            else                   chk("pix_data", 32'(oPixel), 32'(pix_q.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic samp;
        @(negedge clock);
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        iAddr[i*AW +: AW] = AW'(a);
        iData[i*DW +: DW] = DW'(d);
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.a = AW'(a);
        e.d = DW'(d);
        wr_q.push_back(e);
    endtask

    task automatic preload(input int a, input int d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = DW'(d);
        tick;
    endtask

    initial begin
        reset = 1'b1; iActive = 1'b0; iX = '0; iY = '0;
        iReq = '0; iReq_v = '0; iAddr = '0; iData = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2 reset = 1'b0;
        tick;
        preload(1605, 'hA5);
        for (int x = 0; x < 4; x++) preload(2400 + x, 'h50 + x);
        preload(0, 'hC3);
        ld_en = 1'b0;
        tick;

        // reset state
        samp;
        chk("rst_vblank", 32'(oVblank), 1);
        chk("rst_we", 32'(oMemWe), 0);
        chk("rst_gnt", 32'(oGnt), 0);
        chk("rst_pv", 32'(oPixelValid), 0);
        chk("rst_fd", 32'(oFrameDone), 0);
        chk("rst_err", 32'(oAddrErr), 0);
        chk("rst_addr", 32'(oMemAddr), 0);

        // round-robin in VBLANK straight out of reset
        tick;
        reset = 1'b1; iReq = 2'b11;
        set_wr(0, 100, 'h11); set_wr(1, 200, 'h22);
        gnt_q.push_back(2'b01); push_wr(100, 'h11);
        samp; chk("p1_vblank", 32'(oVblank), 1);
        tick;
        set_wr(0, 101, 'h33);
        gnt_q.push_back(2'b10); push_wr(200, 'h22);
        samp; chk("p1_addr_w0", 32'(oMemAddr), 100); chk("p1_we0", 32'(oMemWe), 1);
        tick;
        gnt_q.push_back(2'b01); push_wr(101, 'h33);
        samp; chk("p1_addr_w1", 32'(oMemAddr), 200);
        tick;
        iReq = '0;
        samp; chk("p1_addr_w0b", 32'(oMemAddr), 101); chk("p1_gnt_off", 32'(oGnt), 0);

        // scan-out read of (5,2) -> word 1605
        tick;
        iActive = 1'b1; iX = 10'd5; iY = 10'd2;
        pix_q.push_back(8'hA5);
        samp; chk("p2_we_idle", 32'(oMemWe), 0);
        tick;
        iActive = 1'b0;
        samp; chk("p2_addr", 32'(oMemAddr), 1605); chk("p2_we", 32'(oMemWe), 0);
        tick;
        samp; chk("p2_pv_early", 32'(oPixelValid), 0);
        tick;
        samp; chk("p2_pv", 32'(oPixelValid), 1); chk("p2_pix", 32'(oPixel), 'hA5);

        // request pending across an active line
        tick;
        iActive = 1'b1; iX = 10'd0; iY = 10'd3; iReq = 2'b01; set_wr(0, 300, 'h44);
        pix_q.push_back(8'h50);
        samp; chk("p3_hold", 32'(oGnt), 0);
        for (int x = 1; x < 4; x++) begin
            tick;
            iX = 10'(x);
            pix_q.push_back(8'(8'h50 + x));
            samp; chk("p3_hold", 32'(oGnt), 0);
        end
        tick;
        iActive = 1'b0;
        samp; chk("p3_scan_tail", 32'(oGnt), 0);
        tick;
        gnt_q.push_back(2'b01); push_wr(300, 'h44);
        samp; chk("p3_hblank_gnt", 32'(oGnt), 'b01);

        // out-of-range write, then the last legal word
        tick;
        iReq = 2'b01; set_wr(0, 480000, 'h55);
        gnt_q.push_back(2'b01);
        samp; chk("p4_err_pre", 32'(oAddrErr), 0);
        tick;
        iReq = 2'b10; set_wr(1, 479999, 'h66);
        gnt_q.push_back(2'b10); push_wr(479999, 'h66);
        samp; chk("p4_we_blocked", 32'(oMemWe), 0); chk("p4_err", 32'(oAddrErr), 1);
        tick;
        iReq = '0;
        samp; chk("p4_edge_we", 32'(oMemWe), 1); chk("p4_edge_addr", 32'(oMemAddr), 479999);
        repeat (3) tick;
        samp; chk("p4_err_sticky", 32'(oAddrErr), 1);

        // VBLANK-only variant: closed in HBLANK, opens after the last line
        tick;
        iY = 10'd10; iReq_v = 2'b01;
        samp; chk("p5_hblank_v", 32'(v_oGnt), 0);
        tick;
        samp; chk("p5_hblank_v", 32'(v_oGnt), 0);
        tick;
        iActive = 1'b1; iX = 10'd799; iY = 10'd599;
        pix_q.push_back(8'h66);
        samp; chk("p5_active_v", 32'(v_oGnt), 0);
        tick;
        iActive = 1'b0;
        samp; chk("p5_fall_fd", 32'(oFrameDone), 0); chk("p5_fall_v", 32'(v_oGnt), 0);
        tick;
        samp;
        chk("p5_fd", 32'(oFrameDone), 1);
        chk("p5_vb", 32'(oVblank), 1);
        chk("p5_v_gnt", 32'(v_oGnt), 'b01);
        chk("p5_v_fd", 32'(v_oFrameDone), 1);
        tick;
        iReq_v = '0;
        samp; chk("p5_fd_pulse", 32'(oFrameDone), 0);

        // reset asserted while a grant and a write are in flight
        tick;
        iActive = 1'b1; iX = 10'd0; iY = 10'd0;
        pix_q.push_back(8'hC3);
        tick;
        iActive = 1'b0;
        samp; chk("p6_scan_tail", 32'(oGnt), 0);
        tick;
        iReq = 2'b01; set_wr(0, 700, 'h77);
        gnt_q.push_back(2'b01); push_wr(700, 'h77);
        tick;
        iReq = 2'b10; set_wr(1, 800, 'h88);
        gnt_q.push_back(2'b10);
        samp;
        #2;
        chk("p6_we_pre", 32'(oMemWe), 1);
        chk("p6_pv_pre", 32'(oPixelValid), 1);
        chk("p6_gnt_pre", 32'(oGnt), 'b10);
        reset = 1'b0;
        #1;
        chk("p6_we_rst", 32'(oMemWe), 0);
        chk("p6_gnt_rst", 32'(oGnt), 0);
        chk("p6_pv_rst", 32'(oPixelValid), 0);
        chk("p6_vb_rst", 32'(oVblank), 1);
        iReq = '0;
        repeat (2) tick;
        reset = 1'b1;
        repeat (2) tick;
        chk("p6_ram_kept", 32'(mem[101]), 'h33);

        chk("gnt_q_left", 32'(gnt_q.size()), 0);
        chk("wr_q_left", 32'(wr_q.size()), 0);
        chk("pix_q_left", 32'(pix_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
